// File: rtl/pixel_stream_receiver.sv
// Receiving end of the sensor readout link: samples sensor words on CLK, buffers them in a
// word FIFO and unpacks them into a coordinate-tagged valid/ready pixel stream.

// Two-flop synchronizer plus one edge-detect flop; the caller derives rise/fall from lvl/prev.
module psr_sync_edge (
    input  logic CLK,
    input  logic RESET,
    input  logic din,
    output logic lvl,
    output logic prev
);
    logic meta;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) {prev, lvl, meta} <= '0;
        else        {prev, lvl, meta} <= {lvl, meta, din};
    end
endmodule

module pixel_stream_receiver #(
    parameter int PIXEL_BITS   = 8,
    parameter int BUS_WIDTH    = 4,
    parameter int ARRAY_WIDTH  = 128,
    parameter int ARRAY_HEIGHT = 128,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            OUTPUT_CLK,
    input  logic [BUS_WIDTH*PIXEL_BITS-1:0] DATA_OUT,
    input  logic                            FRAME_FINISHED,
    output logic                            PIX_VALID,
    input  logic                            PIX_READY,
    output logic [PIXEL_BITS-1:0]           PIX_DATA,
    output logic [$clog2(ARRAY_WIDTH)-1:0]  PIX_X,
    output logic [$clog2(ARRAY_HEIGHT)-1:0] PIX_Y,
    output logic                            PIX_LAST,
    output logic                            FRAME_ERROR,
    output logic                            OVERFLOW
);
    localparam int WORDS = ARRAY_WIDTH * ARRAY_HEIGHT / BUS_WIDTH;
    localparam int CW    = $clog2(WORDS + 2);
    localparam int XW    = $clog2(ARRAY_WIDTH);
    localparam int YW    = $clog2(ARRAY_HEIGHT);
    localparam int LW    = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);

    typedef logic [BUS_WIDTH-1:0][PIXEL_BITS-1:0] word_t;
    typedef struct packed {
        logic  sof;
        word_t pix;
    } entry_t;

    typedef enum logic {SYNC, RECV} state_t;

    // ---------------- input sampling ----------------
    logic [1:0] ctl_in, ctl_lvl, ctl_prev;
    logic       oc_rise, ff_rise, ff_fall;
    word_t      data_s1, data_s2;

    assign ctl_in = {FRAME_FINISHED, OUTPUT_CLK};

    for (genvar g = 0; g < 2; g++) begin : g_sync
        psr_sync_edge u_sync (
            .CLK  (CLK),
            .RESET(RESET),
            .din  (ctl_in[g]),
            .lvl  (ctl_lvl[g]),
            .prev (ctl_prev[g])
        );
    end

    assign oc_rise = ctl_lvl[0] & ~ctl_prev[0];
    assign ff_rise = ctl_lvl[1] & ~ctl_prev[1];
    assign ff_fall = ~ctl_lvl[1] & ctl_prev[1];

    // Data is delayed to line up with the synchronized strobe.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            data_s1 <= '0;
            data_s2 <= '0;
        end else begin
            data_s1 <= DATA_OUT;
            data_s2 <= data_s1;
        end
    end

    // ---------------- frame FSM ----------------
    state_t        state, state_nxt;
    logic          push_req, start_frame, end_frame;
    logic [CW-1:0] cnt, cnt_inc;
    logic          frame_bad, sof_pend;
    logic          full, empty, pop, push, drop, bad_frame;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= SYNC;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        push_req    = 1'b0;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        case (state)
            SYNC: if (ff_fall) begin
                state_nxt   = RECV;
                start_frame = 1'b1;
            end
            RECV: begin
                push_req = oc_rise;
                if (ff_rise) begin
                    state_nxt = SYNC;
                    end_frame = 1'b1;
                end
            end
            default: state_nxt = SYNC;
        endcase
    end

    // A word arriving with the frame-end edge is counted before the length check.
    assign cnt_inc   = (push_req && cnt != CW'(WORDS + 1)) ? cnt + CW'(1) : cnt;
    assign drop      = push_req && full && !pop;
    assign push      = push_req && !drop;
    assign bad_frame = (cnt_inc != CW'(WORDS)) || frame_bad || drop;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt         <= '0;
            frame_bad   <= 1'b0;
            sof_pend    <= 1'b0;
            FRAME_ERROR <= 1'b0;
            OVERFLOW    <= 1'b0;
        end else begin
            FRAME_ERROR <= end_frame && bad_frame;
            OVERFLOW    <= OVERFLOW | drop;
            if (start_frame) begin
                cnt       <= '0;
                frame_bad <= 1'b0;
                sof_pend  <= 1'b1;
            end else if (push_req) begin
                cnt <= cnt_inc;
                if (drop) frame_bad <= 1'b1;
                if (push) sof_pend  <= 1'b0;
            end
        end
    end

    // ---------------- word FIFO ----------------
    // The sof tag marks a frame's first word so coordinates realign only when it reaches the unpacker.
    entry_t        mem [FIFO_DEPTH];
    entry_t        head;
    logic [AW:0]   wr_ptr, rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr[AW-1:0]] <= '{sof: sof_pend, pix: data_s2};
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // ---------------- unpacker ----------------
    word_t         uw;
    logic [LW-1:0] lane;
    logic          busy, fire, last_lane;
    logic [XW-1:0] x;
    logic [YW-1:0] y;

    assign fire      = busy && PIX_READY;
    assign last_lane = (lane == LW'(BUS_WIDTH - 1));
    assign pop       = (!busy || (fire && last_lane)) && !empty;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            uw   <= '0;
            lane <= '0;
            busy <= 1'b0;
        end else if (pop) begin
            uw   <= head.pix;
            lane <= '0;
            busy <= 1'b1;
        end else if (fire) begin
            if (last_lane) busy <= 1'b0;
            else           lane <= lane + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            x <= '0;
            y <= '0;
        end else if (pop && head.sof) begin
            x <= '0;
            y <= '0;
        end else if (fire) begin
            if (x == XW'(ARRAY_WIDTH - 1)) begin
                x <= '0;
                y <= (y == YW'(ARRAY_HEIGHT - 1)) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    assign PIX_VALID = busy;
    assign PIX_DATA  = uw[lane];
    assign PIX_X     = x;
    assign PIX_Y     = y;
    assign PIX_LAST  = busy && (x == XW'(ARRAY_WIDTH - 1)) && (y == YW'(ARRAY_HEIGHT - 1));

endmodule
